// File: rtl/pwrseq_pkg.sv
// Shared types and helpers for the power-up / bring-up sequencer.
package pwrseq_pkg;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_ACK   = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } pwrseq_state_e;

  // Bits needed to index n items; never less than one so a single-stage
  // build still gets a usable index port.
  function automatic int pwrseq_clog2(input int n);
    int bits_v;
    bits_v = 32'sd1;
    for (int i = 32'sd1; i < 32'sd31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        bits_v = i + 32'sd1;
      end
    end
    return bits_v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with async active-low clear. Used for reset release
// and for acks arriving from foreign clock domains.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // First stage may go metastable; second stage gives it a cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/power_sequencer.sv
// N-stage ordered power-up sequencer: each stage waits a programmable delay,
// raises its enable, and optionally waits (with timeout) for an acknowledge.
module power_sequencer
  import pwrseq_pkg::*;
#(
  parameter int                         N_STAGES     = 4,
  parameter int                         CNT_W        = 16,
  parameter logic [N_STAGES*CNT_W-1:0]  STAGE_DELAYS = {16'd5, 16'd0, 16'd100, 16'd5000},
  parameter logic [N_STAGES-1:0]        ACK_MASK     = 4'b0101,
  parameter logic [CNT_W-1:0]           TIMEOUT      = 16'd50000,
  localparam int                        STG_W        = pwrseq_clog2(N_STAGES)
) (
  input  logic                clk_25M,
  input  logic                rst_n,
  input  logic                restart,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] stage_en,
  output logic [STG_W-1:0]    cur_stage,
  output logic                all_done,
  output logic                timeout_err,
  output logic [STG_W-1:0]    err_stage
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - CNT_W'(1'b1);

  logic                rst_sync_s;
  logic [N_STAGES-1:0] ack_sync_s;
  logic [CNT_W-1:0]    delay_tab_s [N_STAGES];
  logic [CNT_W-1:0]    delay_sel_s;
  logic                ack_sel_s;
  logic                mask_sel_s;
  logic                last_stage_s;

  pwrseq_state_e       state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [N_STAGES-1:0] stage_en_r;
  logic [STG_W-1:0]    cur_stage_r;
  logic [STG_W-1:0]    err_stage_r;
  logic                all_done_r;
  logic                timeout_err_r;

  // Reset asserts immediately, releases two clock edges after rst_n rises.
  sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk   (clk_25M),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_sync_s)
  );

  // Acks may come from other domains; only the synchronised copy is used.
  sync_2ff #(.WIDTH(N_STAGES)) u_ack_sync (
    .clk   (clk_25M),
    .rst_n (rst_n),
    .d     (stage_ack),
    .q     (ack_sync_s)
  );

  for (genvar g = 0; g < N_STAGES; g++) begin : g_delay
    assign delay_tab_s[g] = STAGE_DELAYS[g*CNT_W +: CNT_W];
  end

  // Per-stage parameters selected by the active stage index.
  always_comb begin
    delay_sel_s  = delay_tab_s[cur_stage_r];
    ack_sel_s    = ack_sync_s[cur_stage_r];
    mask_sel_s   = ACK_MASK[cur_stage_r];
    last_stage_s = (cur_stage_r == STG_W'(N_STAGES - 1));
  end

  // Sequencer FSM: delay, ack wait, completion and timeout; restart wins.
  always_ff @(posedge clk_25M or negedge rst_sync_s) begin
    if (!rst_sync_s) begin
      state_r       <= S_DELAY;
      cnt_r         <= {CNT_W{1'b0}};
      stage_en_r    <= {N_STAGES{1'b0}};
      cur_stage_r   <= {STG_W{1'b0}};
      err_stage_r   <= {STG_W{1'b0}};
      all_done_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else if (restart) begin
      state_r       <= S_DELAY;
      cnt_r         <= {CNT_W{1'b0}};
      stage_en_r    <= {N_STAGES{1'b0}};
      cur_stage_r   <= {STG_W{1'b0}};
      err_stage_r   <= {STG_W{1'b0}};
      all_done_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        S_DELAY: begin
          if (cnt_r == delay_sel_s) begin
            stage_en_r[cur_stage_r] <= 1'b1;
            cnt_r                   <= {CNT_W{1'b0}};
            if (mask_sel_s) begin
              state_r <= S_ACK;
            end else if (last_stage_s) begin
              state_r <= S_DONE;
            end else begin
              cur_stage_r <= cur_stage_r + STG_W'(1'b1);
              state_r     <= S_DELAY;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        S_ACK: begin
          // Ack is tested first so it beats a timeout landing on the same cycle.
          if (ack_sel_s) begin
            cnt_r <= {CNT_W{1'b0}};
            if (last_stage_s) begin
              state_r <= S_DONE;
            end else begin
              cur_stage_r <= cur_stage_r + STG_W'(1'b1);
              state_r     <= S_DELAY;
            end
          end else if ((TIMEOUT != {CNT_W{1'b0}}) && (cnt_r == TIMEOUT_LAST)) begin
            state_r       <= S_ERR;
            timeout_err_r <= 1'b1;
            err_stage_r   <= cur_stage_r;
            cnt_r         <= {CNT_W{1'b0}};
          end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        S_DONE: begin
          all_done_r <= 1'b1;
          stage_en_r <= {N_STAGES{1'b1}};
        end
        S_ERR: begin
          timeout_err_r <= 1'b1;
        end
        default: begin
          state_r <= S_ERR;
        end
      endcase
    end
  end

  assign stage_en    = stage_en_r;
  assign cur_stage   = cur_stage_r;
  assign all_done    = all_done_r;
  assign timeout_err = timeout_err_r;
  assign err_stage   = err_stage_r;

endmodule

// File: tb/tb_power_sequencer.sv
// Self-checking bench for power_sequencer. A timeline model turns per-stage
// delays and ack rise times into the cycle each output should change.
module tb_power_sequencer;

  localparam int N   = 4;
  localparam int TO  = 100;
  localparam int INF = 1000000000;
  localparam logic [63:0] DELAYS = {16'd5, 16'd0, 16'd3, 16'd10};
  localparam logic [3:0]  MASK   = 4'b0101;

  logic         clk_25M   = 1'b0;
  logic         rst_n     = 1'b1;
  logic         restart   = 1'b0;
  logic [N-1:0] stage_ack = 4'b0000;
  logic [N-1:0] stage_en;
  logic [1:0]   cur_stage;
  logic [1:0]   err_stage;
  logic         all_done;
  logic         timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model timeline (absolute cycle numbers).
  int ack_rise [N];
  int entry_t  [N];
  int en_t     [N];
  int done_t, err_t, err_stg, start_t;

  always #20 clk_25M = ~clk_25M;

  power_sequencer #(
    .N_STAGES     (N),
    .CNT_W        (16),
    .STAGE_DELAYS (DELAYS),
    .ACK_MASK     (MASK),
    .TIMEOUT      (16'd100)
  ) dut (
    .clk_25M     (clk_25M),
    .rst_n       (rst_n),
    .restart     (restart),
    .stage_ack   (stage_ack),
    .stage_en    (stage_en),
    .cur_stage   (cur_stage),
    .all_done    (all_done),
    .timeout_err (timeout_err),
    .err_stage   (err_stage)
  );

  function automatic int delay_of(input int i);
    logic [63:0] d;
    d = DELAYS;
    return int'(d[i*16 +: 16]);
  endfunction

  function automatic bit masked(input int i);
    logic [3:0] m;
    m = MASK;
    return m[i];
  endfunction

  // Walk the stages: entry, enable time, ack wait outcome, done or timeout.
  function automatic void build_model(input int start);
    int e, a, s, c, nxt;
    start_t = start;
    done_t  = INF;
    err_t   = INF;
    err_stg = 0;
    for (int i = 0; i < N; i++) begin
      entry_t[i] = INF;
      en_t[i]    = INF;
    end
    e = start;
    for (int i = 0; i < N; i++) begin
      entry_t[i] = e;
      en_t[i]    = e + delay_of(i) + 1;
      nxt        = en_t[i];
      if (masked(i)) begin
        a = en_t[i];
        s = (ack_rise[i] >= INF) ? INF : ack_rise[i] + 2;
        c = (s > a) ? s : a;
        if (c > a + TO - 1) begin
          err_t   = a + TO;
          err_stg = i;
          break;
        end
        nxt = c + 1;
      end
      if (i == N - 1) done_t = nxt + 1;
      else e = nxt;
    end
  endfunction

  function automatic logic [9:0] exp_vec(input int c);
    logic [3:0] en;
    logic [1:0] cs;
    logic [1:0] es;
    en = 4'b0000;
    cs = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (c >= en_t[i]) en[i] = 1'b1;
      if (c >= entry_t[i]) cs = 2'(i);
    end
    es = (c >= err_t) ? 2'(err_stg) : 2'd0;
    return {en, cs, (c >= done_t), (c >= err_t), es};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {stage_en, cur_stage, all_done, timeout_err, err_stage};
  endfunction

  function automatic int end_of_run();
    return ((done_t < err_t) ? done_t : err_t) + 3;
  endfunction

  task automatic step();
    @(negedge clk_25M);
    cyc++;
  endtask

  // Masked acks follow their rise time; unmasked acks are noise and must be ignored.
  task automatic drive_inputs();
    restart = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (masked(i)) stage_ack[i] = (cyc >= ack_rise[i]);
      else stage_ack[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Pulse restart this cycle; the new sequence starts next cycle.
  task automatic do_restart(input int off0, input int off2);
    restart = 1'b1;
    for (int i = 0; i < N; i++) ack_rise[i] = INF;
    ack_rise[0] = (off0 >= INF) ? INF : cyc + 1 + off0;
    ack_rise[2] = (off2 >= INF) ? INF : cyc + 1 + off2;
    build_model(cyc + 1);
  endtask

  task automatic test_reset();
    int p;
    for (int i = 0; i < N; i++) ack_rise[i] = INF;
    build_model(INF);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 10'd0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", obs_vec(), 10'd0);
    end
    repeat (3) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec(cyc));
      end
      drive_inputs();
    end
    rst_n = 1'b1;
    p = cyc;
    build_model(p + 2);
    while (cyc < p + 2) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec(cyc));
      end
      drive_inputs();
    end
  endtask

  // Current cycle is t0: ack0 from t0+12, ack2 from t0+24.
  task automatic test_basic();
    int t0, first_en3, first_done, stop;
    t0 = start_t;
    first_en3  = INF;
    first_done = INF;
    ack_rise[0] = t0 + 12;
    ack_rise[2] = t0 + 24;
    build_model(t0);
    drive_inputs();
    stop = end_of_run();
    while (cyc < stop && cyc < t0 + 500) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL basic t=%0d got=%b exp=%b", cyc - t0, obs_vec(), exp_vec(cyc));
      end
      if (stage_en[3] && first_en3 >= INF) first_en3 = cyc;
      if (all_done && first_done >= INF) first_done = cyc;
      drive_inputs();
    end
    // Delays 10,3,0,5: en3 at t0+33, all_done one cycle later.
    checks++;
    if (first_en3 != t0 + 33) begin
      failures++;
      $display("FAIL basic_en3_time got=%0d exp=%0d", first_en3 - t0, 33);
    end
    checks++;
    if (first_done != t0 + 34) begin
      failures++;
      $display("FAIL basic_done_time got=%0d exp=%0d", first_done - t0, 34);
    end
  endtask

  task automatic test_timeout();
    int first_err, stop;
    first_err = INF;
    do_restart(INF, INF);
    stop = end_of_run();
    while (cyc < stop && cyc < start_t + 500) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL timeout t=%0d got=%b exp=%b", cyc - start_t, obs_vec(), exp_vec(cyc));
      end
      if (timeout_err && first_err >= INF) first_err = cyc;
      drive_inputs();
    end
    // Ack wait entered at +11; 100 cycles later the error is visible.
    checks++;
    if (first_err != start_t + 111) begin
      failures++;
      $display("FAIL timeout_time got=%0d exp=%0d", first_err - start_t, 111);
    end
    checks++;
    if ({stage_en, all_done, timeout_err, err_stage} !== {4'b0001, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL timeout_state got=%b exp=%b", {stage_en, all_done, timeout_err, err_stage},
               {4'b0001, 1'b0, 1'b1, 2'd0});
    end
  endtask

  // From S_ERR; runs until stage 2 is entered so the next test can restart there.
  task automatic test_restart_from_err();
    int r, first_en0;
    r = cyc;
    first_en0 = INF;
    do_restart(int'($urandom_range(0, 20)), int'($urandom_range(10, 60)));
    step();
    checks++;
    if (obs_vec() !== 10'd0) begin
      failures++;
      $display("FAIL restart_err_clear got=%b exp=%b", obs_vec(), 10'd0);
    end
    drive_inputs();
    while (cyc < entry_t[2] && cyc < r + 500) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL restart_err t=%0d got=%b exp=%b", cyc - start_t, obs_vec(), exp_vec(cyc));
      end
      if (stage_en[0] && first_en0 >= INF) first_en0 = cyc;
      drive_inputs();
    end
    checks++;
    if (first_en0 != r + 12) begin
      failures++;
      $display("FAIL restart_err_en0 got=%0d exp=%0d", first_en0 - r, 12);
    end
  endtask

  // Stage 2 has zero delay, so its enable would rise this very cycle.
  task automatic test_restart_mid_delay2();
    int stop;
    do_restart(3, 40);
    step();
    checks++;
    if ({stage_en, cur_stage} !== {4'b0000, 2'd0}) begin
      failures++;
      $display("FAIL restart_mid got=%b exp=%b", {stage_en, cur_stage}, {4'b0000, 2'd0});
    end
    drive_inputs();
    stop = end_of_run();
    while (cyc < stop && cyc < start_t + 500) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL restart_mid_run t=%0d got=%b exp=%b", cyc - start_t, obs_vec(), exp_vec(cyc));
      end
      drive_inputs();
    end
  endtask

  // Stage 0: synced ack lands on the last wait cycle (ack wins).
  // Stage 2: synced ack lands one cycle too late (timeout, err_stage=2).
  task automatic test_collision();
    int first_cs1, stop;
    first_cs1 = INF;
    do_restart(108, INF);
    ack_rise[2] = en_t[2] + 98;
    build_model(start_t);
    stop = end_of_run();
    while (cyc < stop && cyc < start_t + 600) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL collision t=%0d got=%b exp=%b", cyc - start_t, obs_vec(), exp_vec(cyc));
      end
      if (cur_stage == 2'd1 && first_cs1 >= INF) first_cs1 = cyc;
      drive_inputs();
    end
    checks++;
    if (first_cs1 != start_t + 111) begin
      failures++;
      $display("FAIL collision_advance got=%0d exp=%0d", first_cs1 - start_t, 111);
    end
    checks++;
    if ({stage_en, all_done, timeout_err, err_stage} !== {4'b0111, 1'b0, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL collision_late got=%b exp=%b", {stage_en, all_done, timeout_err, err_stage},
               {4'b0111, 1'b0, 1'b1, 2'd2});
    end
  endtask

  task automatic test_async_reset();
    int stop;
    do_restart(2, 5);
    repeat (20) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL async_pre t=%0d got=%b exp=%b", cyc - start_t, obs_vec(), exp_vec(cyc));
      end
      drive_inputs();
    end
    #5 rst_n = 1'b0;
    #2;
    checks++;
    if (obs_vec() !== 10'd0) begin
      failures++;
      $display("FAIL async_assert got=%b exp=%b", obs_vec(), 10'd0);
    end
    for (int i = 0; i < N; i++) ack_rise[i] = INF;
    build_model(INF);
    repeat (3) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL async_hold cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec(cyc));
      end
      drive_inputs();
    end
    rst_n = 1'b1;
    ack_rise[0] = cyc + 2 + int'($urandom_range(0, 30));
    ack_rise[2] = cyc + 2 + int'($urandom_range(0, 100));
    build_model(cyc + 2);
    stop = end_of_run();
    while (cyc < stop && cyc < start_t + 600) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        failures++;
        $display("FAIL async_after t=%0d got=%b exp=%b", cyc - start_t, obs_vec(), exp_vec(cyc));
      end
      drive_inputs();
    end
  endtask

  // Random ack timing: some runs complete, some time out at stage 0 or 2.
  task automatic test_random();
    int stop;
    for (int k = 0; k < 6; k++) begin
      do_restart(int'($urandom_range(0, 130)), int'($urandom_range(0, 260)));
      stop = end_of_run();
      while (cyc < stop && cyc < start_t + 800) begin
        step();
        checks++;
        if (obs_vec() !== exp_vec(cyc)) begin
          failures++;
          $display("FAIL random%0d t=%0d got=%b exp=%b", k, cyc - start_t, obs_vec(), exp_vec(cyc));
        end
        drive_inputs();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_restart_from_err();
    test_restart_mid_delay2();
    test_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
